// File: rtl/fetch_sequencer.sv
// Fetch PC owner and {pc,instr} fetch buffer in front of a combinational instr_mem.
// Optional J-type predecode when JUMP_PREDECODE_EN is defined.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   next_pc;
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
  logic [AW:0]   count;
  logic          full, pop, push;
  logic          head_load;
  logic [31:0]   head_pc_nxt, head_instr_nxt;
  logic [31:0]   head_pc_p1, head_instr_p1;

  assign full       = (count == DEPTH_C);
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = (state == RUN) & run & ~redirect_valid & (~full | pop);
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign imem_addr  = fetch_pc;
  assign out_pc     = head_pc_p1;
  assign out_instr  = head_instr_p1;
  assign busy       = (state == RUN) | out_valid;

`ifdef JUMP_PREDECODE_EN
  // J-type target keeps the upper PC region and replaces the low 26 bits.
  always_comb begin
    next_pc = fetch_pc + 32'd1;
    if (imem_data[31:26] == 6'b000010)
      next_pc = {fetch_pc[31:26], imem_data[25:0]};
  end
`else
  assign next_pc = fetch_pc + 32'd1;
`endif

  // The head register reflects whichever entry will sit at the head after this edge.
  always_comb begin
    head_load      = 1'b0;
    head_pc_nxt    = fetch_pc;
    head_instr_nxt = imem_data;
    if (!redirect_valid) begin
      if (pop) begin
        if (count > (AW+1)'(1)) begin
          head_load      = 1'b1;
          head_pc_nxt    = buf_pc[rd_ptr_inc];
          head_instr_nxt = buf_instr[rd_ptr_inc];
        end else if (push) begin
          head_load = 1'b1;
        end
      end else if (!out_valid && push) begin
        head_load = 1'b1;
      end
    end
  end

  // Stage p1: control state, pointers and head registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      head_pc_p1    <= '0;
      head_instr_p1 <= '0;
    end else begin
      state <= run ? RUN : IDLE;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= next_pc;
          wr_ptr   <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr_inc;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (head_load) begin
        head_pc_p1    <= head_pc_nxt;
        head_instr_p1 <= head_instr_nxt;
      end
    end
  end

  // Buffer storage carries data only; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= fetch_pc;
      buf_instr[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed runs, expected entries queued by stimulus.
module tb_fetch_sequencer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        jmode = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  fetch_sequencer #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Instruction memory: mem[k] = 8C000000 + k, optionally a J 4 at address 0.
  always_comb begin
    imem_data = 32'h8C00_0000 + imem_addr;
    if (jmode && imem_addr == 32'h0)
      imem_data = 32'h0800_0004;
  end

  // Monitor: every completed handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_entry: got pc=%h instr=%h, expected no entry", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors++;
          $display("FAIL entry: got pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    run = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    jmode = 1'b0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // From IDLE: one edge to enter RUN, then n pushing edges, then run drops.
  task automatic run_for(input int n);
    run = 1'b1;
    repeat (n + 1) @(posedge clk);
    #1 run = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending busy=%b, expected 0 pending busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    // Test 1: sequential stream, then asynchronous reset mid-stream
    do_reset();
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    for (int k = 0; k < 4; k++)
      expect_entry(32'(k), 32'h8C00_0000 + 32'(k));
    run_for(4);
    wait_drain("seq");
    chk("seq_hold_pc", out_pc, 32'h3);
    chk("seq_hold_instr", out_instr, 32'h8C00_0003);
    chk("seq_imem_addr", imem_addr, 32'h4);

    do_reset();
    out_ready = 1'b0;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk("mid_valid_before", {31'b0, out_valid}, 32'h1);
    rst = 1'b1;
    #1 chk("mid_valid_async", {31'b0, out_valid}, 32'h0);
    chk("mid_imem_addr", imem_addr, 32'h0);
    run = 1'b0;
    out_ready = 1'b1;

    // Test 2: backpressure fills the buffer and freezes the fetch PC
    do_reset();
    out_ready = 1'b0;
    run = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("bp_imem_addr", imem_addr, 32'(DEPTH));
    chk("bp_head_pc", out_pc, 32'h0);
    for (int k = 0; k < DEPTH; k++)
      expect_entry(32'(k), 32'h8C00_0000 + 32'(k));
    run = 1'b0;
    out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_imem_after", imem_addr, 32'(DEPTH));

    // Test 3: redirect while full with the head popped on the same edge
    do_reset();
    out_ready = 1'b0;
    run = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rd_full_addr", imem_addr, 32'h2);
    expect_entry(32'h0, 32'h8C00_0000);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    chk("rd_flushed", {31'b0, out_valid}, 32'h0);
    chk("rd_imem_addr", imem_addr, 32'h40);
    expect_entry(32'h40, 32'h8C00_0040);
    expect_entry(32'h41, 32'h8C00_0041);
    expect_entry(32'h42, 32'h8C00_0042);
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    wait_drain("redirect");

    // Test 4: J instruction at address 0
    do_reset();
    jmode = 1'b1;
    expect_entry(32'h0, 32'h0800_0004);
`ifdef JUMP_PREDECODE_EN
    expect_entry(32'h4, 32'h8C00_0004);
    expect_entry(32'h5, 32'h8C00_0005);
`else
    expect_entry(32'h1, 32'h8C00_0001);
    expect_entry(32'h2, 32'h8C00_0002);
`endif
    run_for(3);
    wait_drain("jump");

    // Test 5: redirect to the top word, PC wraps to zero
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    chk("wrap_imem_addr", imem_addr, 32'hFFFF_FFFF);
    expect_entry(32'hFFFF_FFFF, 32'h8BFF_FFFF);
    expect_entry(32'h0, 32'h8C00_0000);
    run_for(2);
    wait_drain("wrap");
    chk("wrap_next_addr", imem_addr, 32'h1);

    // Test 6: run toggles; PC holds in IDLE and fetch resumes there
    do_reset();
    expect_entry(32'h0, 32'h8C00_0000);
    expect_entry(32'h1, 32'h8C00_0001);
    run_for(2);
    chk("tog_busy_run", {31'b0, busy}, 32'h1);
    wait_drain("tog_a");
    chk("tog_hold_addr", imem_addr, 32'h2);
    expect_entry(32'h2, 32'h8C00_0002);
    expect_entry(32'h3, 32'h8C00_0003);
    run_for(2);
    wait_drain("tog_b");
    chk("tog_end_addr", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
